// File: rtl/dac_pkg.sv
// ---------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the DAC pixel router:
//   - state_t      : frame controller state encoding (IDLE, RUN, DONE)
//   - DEF_*        : default frame geometry (8-bit pixels, 8x32 frame, 4 banks)
//   - clog2()      : ceil(log2) helper for elaboration-time constants
//   - DEF_BANK_LSB / DEF_ROW_BIT : pixel-counter bit positions used for the
//     bank select and the checkerboard row parity in the default geometry
// ---------------------------------------------------------------------------
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ROW_W     = 8;
    localparam int DEF_NUM_ROWS  = 32;
    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_PIX       = DEF_ROW_W * DEF_NUM_ROWS;

    // Lowest pixel-counter bit of the bank index (bank = p >> DEF_BANK_LSB).
    localparam int DEF_BANK_LSB  = clog2(DEF_PIX / DEF_NUM_BANKS);
    // Pixel-counter bit that is the LSB of the row number.
    localparam int DEF_ROW_BIT   = clog2(DEF_ROW_W);

endpackage

// File: rtl/dac_sipo.sv
// ---------------------------------------------------------------------------
// dac_sipo
// Serial-to-parallel shifter for one DATA_W-bit pixel, MSB first.
// Ports:
//   clk        : clock
//   clear      : synchronous clear of shift register and bit counter
//   en         : allows bits to be taken (low while the frame is done)
//   bit_in     : serial data bit
//   bit_valid  : bit_in qualifier; a bit is taken on each edge it is high
//   word       : assembled pixel, valid in the cycle word_done is high
//   word_done  : high in the cycle whose edge samples the last bit of a pixel
// word/word_done are combinational so the caller can register the pixel on
// the very edge that samples its last bit.
// ---------------------------------------------------------------------------
module dac_sipo
    import dac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              clear,
    input  logic              en,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] word,
    output logic              word_done
);

    localparam int CNT_W = clog2(DATA_W);

    logic [DATA_W-2:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              take;
    logic              last_bit;

    assign take      = en && bit_valid;
    assign last_bit  = (cnt == CNT_W'(DATA_W - 1));
    assign word      = {shreg, bit_in};
    assign word_done = take && last_bit;

    // Gaps simply hold shreg and cnt, so a pixel may be spread over any
    // number of cycles.
    always_ff @(posedge clk) begin
        if (clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (take) begin
            shreg <= word[DATA_W-2:0];
            cnt   <= last_bit ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dac_pixel_router.sv
// ---------------------------------------------------------------------------
// dac_pixel_router
// Deserialises a gated serial stream into DATA_W-bit pixels and writes each
// pixel into the odd or even half of one of NUM_BANKS banks. Pixel p goes to
// bank p / BANK_PIX at address (p mod BANK_PIX) >> 1; the half follows a
// row-alternating checkerboard (odd when row+col is even).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   so_data      : serial bit, MSB of each pixel first
//   so_valid     : so_data qualifier
//   restart      : re-arm for the next frame (only honoured once done)
//   oem_dataout  : pixel being written (held until the next write)
//   oem_addr     : address within the selected bank half
//   odd_wr       : one-hot, one-cycle write strobe for the odd halves
//   even_wr      : one-hot, one-cycle write strobe for the even halves
//   oem_finish   : frame complete, held until rst or restart
//   busy         : frame in progress
//   overrun      : only with DAC_OVERRUN_EN defined; sticky flag set when
//                  bits arrive after the frame is complete
// ---------------------------------------------------------------------------
module dac_pixel_router
    import dac_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ROW_W     = DEF_ROW_W,
    parameter int NUM_ROWS  = DEF_NUM_ROWS,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int ADDR_W    = clog2((ROW_W * NUM_ROWS) / (2 * NUM_BANKS))
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 so_data,
    input  logic                 so_valid,
    input  logic                 restart,
    output logic [DATA_W-1:0]    oem_dataout,
    output logic [ADDR_W-1:0]    oem_addr,
    output logic [NUM_BANKS-1:0] odd_wr,
    output logic [NUM_BANKS-1:0] even_wr,
    output logic                 oem_finish,
    output logic                 busy
`ifdef DAC_OVERRUN_EN
    ,
    output logic                 overrun
`endif
);

    localparam int PIX      = ROW_W * NUM_ROWS;
    localparam int P_W      = clog2(PIX) + 1;
    localparam int BANK_LSB = clog2(PIX / NUM_BANKS);
    localparam int ROW_BIT  = clog2(ROW_W);

    state_t                state;
    state_t                next_state;
    logic [P_W-1:0]        p;
    logic [DATA_W-1:0]     word;
    logic                  word_done;
    logic                  restart_ok;
    logic                  wr_active;
    logic                  last_pix;
    logic                  odd_sel;
    logic [NUM_BANKS-1:0]  bank_oh;

    assign restart_ok = restart && (state == DONE);
    assign wr_active  = (|odd_wr) || (|even_wr);
    assign last_pix   = (p == P_W'(PIX - 1));
    assign busy       = (state == RUN);

    // Power-of-2 geometry turns every division into bit slicing: the row
    // LSB is p[ROW_BIT] and the column LSB is p[0], so row+col is even
    // exactly when those two bits match.
    assign odd_sel = ~(p[ROW_BIT] ^ p[0]);
    assign bank_oh = NUM_BANKS'(1) << p[P_W-1:BANK_LSB];

    dac_sipo #(
        .DATA_W    (DATA_W)
    ) u_sipo (
        .clk       (clk),
        .clear     (rst || restart_ok),
        .en        (state != DONE),
        .bit_in    (so_data),
        .bit_valid (so_valid),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The frame ends on the edge that closes the strobe cycle of the last
    // pixel, which is also when p steps past PIX-1.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (so_valid)              next_state = RUN;
            RUN:  if (wr_active && last_pix) next_state = DONE;
            DONE: if (restart)               next_state = IDLE;
            default:                         next_state = IDLE;
        endcase
    end

    // Write port and pixel counter. p advances at the end of the strobe
    // cycle; the next pixel needs at least DATA_W more edges, so routing
    // always sees the updated index.
    always_ff @(posedge clk) begin
        if (rst) begin
            oem_dataout <= '0;
            oem_addr    <= '0;
            odd_wr      <= '0;
            even_wr     <= '0;
            oem_finish  <= 1'b0;
            p           <= '0;
        end else begin
            odd_wr  <= '0;
            even_wr <= '0;
            if (word_done) begin
                oem_dataout <= word;
                oem_addr    <= p[BANK_LSB-1:1];
                if (odd_sel) begin
                    odd_wr  <= bank_oh;
                end else begin
                    even_wr <= bank_oh;
                end
            end
            if (restart_ok) begin
                p          <= '0;
                oem_finish <= 1'b0;
            end else if (wr_active) begin
                p <= p + P_W'(1);
                if (last_pix) begin
                    oem_finish <= 1'b1;
                end
            end
        end
    end

`ifdef DAC_OVERRUN_EN
    // Bits arriving after the frame are dropped but remembered here.
    always_ff @(posedge clk) begin
        if (rst || restart_ok) begin
            overrun <= 1'b0;
        end else if ((state == DONE) && so_valid) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dac_pixel_router.sv
// ---------------------------------------------------------------------------
// tb_dac_pixel_router
// Scoreboard bench for dac_pixel_router in its default geometry (8-bit
// pixels, 8x32 frame, 4 banks). Each pixel's expected write is derived from
// its frame index with plain arithmetic and queued when its last bit is
// driven; a monitor pops and compares on every write strobe.
// ---------------------------------------------------------------------------
module tb_dac_pixel_router;

    localparam int DATA_W    = 8;
    localparam int ROW_W     = 8;
    localparam int NUM_ROWS  = 32;
    localparam int NUM_BANKS = 4;
    localparam int PIX       = ROW_W * NUM_ROWS;
    localparam int BANK_PIX  = PIX / NUM_BANKS;
    localparam int ADDR_W    = 5;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [ADDR_W-1:0]    addr;
        logic [NUM_BANKS-1:0] odd;
        logic [NUM_BANKS-1:0] even;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 so_data = 1'b0;
    logic                 so_valid = 1'b0;
    logic                 restart = 1'b0;
    logic [DATA_W-1:0]    oem_dataout;
    logic [ADDR_W-1:0]    oem_addr;
    logic [NUM_BANKS-1:0] odd_wr;
    logic [NUM_BANKS-1:0] even_wr;
    logic                 oem_finish;
    logic                 busy;
`ifdef DAC_OVERRUN_EN
    logic                 overrun;
`endif

    exp_t exp_q[$];
    exp_t mon_act;
    exp_t mon_exp;
    int   model_p = 0;
    int   checks = 0;
    int   errors = 0;
    int   odd_cnt[NUM_BANKS];
    int   even_cnt[NUM_BANKS];
    int   strobe_total = 0;

    dac_pixel_router dut (
        .clk         (clk),
        .rst         (rst),
        .so_data     (so_data),
        .so_valid    (so_valid),
        .restart     (restart),
        .oem_dataout (oem_dataout),
        .oem_addr    (oem_addr),
        .odd_wr      (odd_wr),
        .even_wr     (even_wr),
        .oem_finish  (oem_finish),
        .busy        (busy)
`ifdef DAC_OVERRUN_EN
        ,
        .overrun     (overrun)
`endif
    );

    always #5 clk = ~clk;

    // Reference routing: index -> bank, address and checkerboard half.
    function automatic exp_t expFor(input int pix, input logic [DATA_W-1:0] d);
        exp_t e;
        int   bank;
        int   row;
        int   col;
        bank   = pix / BANK_PIX;
        row    = pix / ROW_W;
        col    = pix % ROW_W;
        e.data = d;
        e.addr = ADDR_W'((pix % BANK_PIX) / 2);
        e.odd  = '0;
        e.even = '0;
        if (((row + col) % 2) == 0) begin
            e.odd[bank] = 1'b1;
        end else begin
            e.even[bank] = 1'b1;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // One bit slot: inputs change on the falling edge, sampled on the next rise.
    task automatic applyStimulus(input logic valid, input logic data);
        @(negedge clk);
        so_valid = valid;
        so_data  = data;
    endtask

    // Sends one pixel MSB first, optionally with gap_len idle slots before
    // bit gap_after. The expectation is queued as the last bit goes out.
    task automatic sendPixel(input logic [DATA_W-1:0] d, input int gap_after,
                             input int gap_len);
        for (int i = 0; i < DATA_W; i++) begin
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    applyStimulus(1'b0, 1'b0);
                end
            end
            if ((i == DATA_W - 1) && (model_p < PIX)) begin
                exp_q.push_back(expFor(model_p, d));
                model_p++;
            end
            applyStimulus(1'b1, d[DATA_W-1-i]);
        end
    endtask

    task automatic sendRandomPixel();
        int gap_len;
        gap_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        sendPixel(DATA_W'($urandom), int'($urandom_range(0, DATA_W - 1)), gap_len);
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if ((odd_wr | even_wr) != '0) begin
            strobe_total++;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (odd_wr[b])  odd_cnt[b]++;
                if (even_wr[b]) even_cnt[b]++;
            end
            mon_act.data = oem_dataout;
            mon_act.addr = oem_addr;
            mon_act.odd  = odd_wr;
            mon_act.even = even_wr;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_strobe: got odd=%b even=%b data=0x%0h, required no strobe",
                         odd_wr, even_wr, oem_dataout);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("[TB] FAIL write: got data=0x%0h addr=%0d odd=%b even=%b, required data=0x%0h addr=%0d odd=%b even=%b",
                             mon_act.data, mon_act.addr, mon_act.odd, mon_act.even,
                             mon_exp.data, mon_exp.addr, mon_exp.odd, mon_exp.even);
                end
            end
        end
    end

    initial begin
        logic [DATA_W-1:0]    d;
        logic [NUM_BANKS-1:0] gap_seen;

        for (int b = 0; b < NUM_BANKS; b++) begin
            odd_cnt[b]  = 0;
            even_cnt[b] = 0;
        end

        // Reset defaults.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_dataout", 32'(oem_dataout), 0);
        checkOutput("rst_addr", 32'(oem_addr), 0);
        checkOutput("rst_odd_wr", 32'(odd_wr), 0);
        checkOutput("rst_even_wr", 32'(even_wr), 0);
        checkOutput("rst_finish", 32'(oem_finish), 0);
        checkOutput("rst_busy", 32'(busy), 0);
`ifdef DAC_OVERRUN_EN
        checkOutput("rst_overrun", 32'(overrun), 0);
`endif
        rst = 1'b0;

        // Single contiguous pixel 0xA5 straight after reset.
        sendPixel(8'hA5, DATA_W, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("p0_odd_wr", 32'(odd_wr), 32'h1);
        checkOutput("p0_dataout", 32'(oem_dataout), 32'hA5);
        checkOutput("p0_addr", 32'(oem_addr), 0);
        checkOutput("p0_busy", 32'(busy), 1);

        // Remainder of the frame: a directed gap at p10, restart held
        // (and ignored) during p20, random pixels and gaps elsewhere.
        while (model_p < PIX) begin
            if (model_p == 10) begin
                d = DATA_W'($urandom);
                for (int i = 0; i < 4; i++) applyStimulus(1'b1, d[DATA_W-1-i]);
                gap_seen = '0;
                for (int g = 0; g < 5; g++) begin
                    applyStimulus(1'b0, 1'b0);
                    gap_seen = gap_seen | odd_wr | even_wr;
                end
                checkOutput("no_strobe_in_gap", 32'(gap_seen), 0);
                for (int i = 4; i < DATA_W; i++) begin
                    if (i == DATA_W - 1) begin
                        exp_q.push_back(expFor(model_p, d));
                        model_p++;
                    end
                    applyStimulus(1'b1, d[DATA_W-1-i]);
                end
            end else if (model_p == 20) begin
                restart = 1'b1;
                sendRandomPixel();
                restart = 1'b0;
            end else begin
                sendRandomPixel();
            end
        end

        // Last strobe cycle, then the cycle after it.
        applyStimulus(1'b0, 1'b0);
        checkOutput("last_strobe_finish", 32'(oem_finish), 0);
        checkOutput("last_strobe_busy", 32'(busy), 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("frame_finish", 32'(oem_finish), 1);
        checkOutput("frame_busy", 32'(busy), 0);
        checkOutput("frame_strobes", 32'(strobe_total), 32'(PIX));
        for (int b = 0; b < NUM_BANKS; b++) begin
            checkOutput($sformatf("odd_cnt_bank%0d", b), 32'(odd_cnt[b]), 32'(BANK_PIX / 2));
            checkOutput($sformatf("even_cnt_bank%0d", b), 32'(even_cnt[b]), 32'(BANK_PIX / 2));
        end

        // Extra bits after the frame must not produce writes.
        for (int i = 0; i < 2 * DATA_W; i++) applyStimulus(1'b1, 1'($urandom));
        applyStimulus(1'b0, 1'b0);
        checkOutput("done_finish_held", 32'(oem_finish), 1);
        checkOutput("done_strobes", 32'(strobe_total), 32'(PIX));
`ifdef DAC_OVERRUN_EN
        checkOutput("overrun_set", 32'(overrun), 1);
`endif

        // Restart re-arms the frame at pixel 0.
        restart = 1'b1;
        applyStimulus(1'b0, 1'b0);
        restart = 1'b0;
        model_p = 0;
        checkOutput("restart_finish", 32'(oem_finish), 0);
        checkOutput("restart_busy", 32'(busy), 0);
`ifdef DAC_OVERRUN_EN
        checkOutput("restart_overrun", 32'(overrun), 0);
`endif
        d = DATA_W'($urandom);
        sendPixel(d, DATA_W, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("restart_p0_odd_wr", 32'(odd_wr), 32'h1);
        checkOutput("restart_p0_addr", 32'(oem_addr), 0);

        // Reset in the middle of pixel 10 discards the partial pixel.
        while (model_p < 10) sendRandomPixel();
        d = DATA_W'($urandom);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, d[DATA_W-1-i]);
        applyStimulus(1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        rst = 1'b0;
        model_p = 0;
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_strobes", 32'(odd_wr | even_wr), 0);
        d = DATA_W'($urandom);
        sendPixel(d, DATA_W, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("midrst_p0_odd_wr", 32'(odd_wr), 32'h1);
        checkOutput("midrst_p0_data", 32'(oem_dataout), 32'(d));

        // Every queued write must have appeared within a bounded time.
        for (int i = 0; (i < 20) && (exp_q.size() != 0); i++) @(negedge clk);
        checkOutput("queue_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_pixel_router.md
Name: dac_pixel_router

Overview:
- Parametrised successor to the fixed 8-bit, 4-bank data arrange controller.
- Deserialises a gated serial bit stream into DATA_W-bit pixels and routes each pixel into one of NUM_BANKS memory banks.
- Each bank is split into odd and even halves by a row-alternating checkerboard.
- Sits between the serial source and the odd/even pixel memories; adds frame restart, a busy indication and configurable geometry.

Parameters:
- DATA_W, 8, bits per pixel (>=2).
- ROW_W, 8, pixels per image row (even power of 2).
- NUM_ROWS, 32, rows per frame; PIX = ROW_W*NUM_ROWS, power of 2.
- NUM_BANKS, 4, memory banks (power of 2); PIX divisible by 2*NUM_BANKS.
- ADDR_W, derived = clog2(PIX/(2*NUM_BANKS)), per-half address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- so_data  in  1  serial data bit, MSB of each pixel first
- so_valid  in  1  so_data qualifier; bit sampled on a clk edge when high
- restart  in  1  re-arm for a new frame; honoured only in DONE
- oem_dataout  out  DATA_W  pixel being written
- oem_addr  out  ADDR_W  address within the selected bank half
- odd_wr  out  NUM_BANKS  one-hot write strobe, odd half of bank i
- even_wr  out  NUM_BANKS  one-hot write strobe, even half of bank i
- oem_finish  out  1  frame complete, held high
- busy  out  1  frame in progress (state RUN)

Behaviour:
- Reset (sync, rst high at edge): all outputs 0; state IDLE; bit counter and pixel counter p cleared; shift register 0.
- State IDLE -> RUN on first sampled bit (so_valid=1). RUN -> DONE at the edge ending the write of pixel PIX-1. DONE -> IDLE on restart=1, clearing p and the bit counter. DONE never exits otherwise.
- Deserialiser: shifts so_data in on every edge with so_valid=1 in IDLE/RUN. Gaps (so_valid=0) hold the partial pixel, with no timeout. Bits are ignored in DONE.
- Write: on the edge that samples bit DATA_W-1 of a pixel, oem_dataout, oem_addr and exactly one strobe bit are registered. The strobe is high for exactly one cycle (latency 1 from last-bit edge). Data and address hold until the next write.
- Back-to-back pixels with no gap are supported: a pixel's duration (DATA_W cycles) always exceeds the 1-cycle write.
- Routing for pixel index p, with BANK_PIX = PIX/NUM_BANKS:
  - bank = p / BANK_PIX
  - oem_addr = (p mod BANK_PIX) >> 1
  - row = p / ROW_W, col = p mod ROW_W
  - odd when (row+col) is even, else even
  - p increments at the edge ending the strobe cycle.
- oem_finish: rises the cycle after the final strobe and stays high until rst or restart.
- busy: equals (state==RUN).
- restart outside DONE: ignored.
- rst mid-frame: aborts the frame immediately; the partial pixel is discarded and no strobe is issued.
- Widths: p is clog2(PIX)+1 bits; the bank and address are slices of p. Per-pixel division is not used; restrictions on the power-of-2 parameters make all divisions bit-slicing.

Optional Feature:
- DAC_OVERRUN_EN.
- Defined: adds output overrun (1 bit, reset 0).
  - Set sticky when so_valid=1 is seen in DONE.
  - Cleared by rst or restart.
  - The bits themselves are still discarded.
- Undefined: no port; extra bits in DONE are silently dropped.

Decomposition:
- Package dac_pkg holds:
  - state encoding typedef (IDLE, RUN, DONE)
  - default geometry constants
  - clog2 helper function
  - bank/parity slice-position localparams
- Sub-module dac_sipo: DATA_W serial-to-parallel shifter with bit counter. Outputs word and a one-cycle word_done; has a clear input driven by restart/rst.

Test Plan:
- Reset defaults: rst held 3 cycles -> all outputs 0, busy=0, oem_finish=0.
- Single pixel: bits 1,0,1,0,0,1,0,1 (0xA5) contiguous from reset -> cycle after 8th edge: odd_wr=4'b0001, oem_dataout=0xA5, oem_addr=0, busy=1.
- Routing/checkerboard: stream pixels 0..9 -> p1 even_wr[0] addr0; p8 even_wr[0] addr4; p9 odd_wr[0] addr4; p64 (extend) odd_wr[1] addr0; p255 odd_wr[3] addr31.
- Gapped input: so_valid low for 5 cycles between bits 3 and 4 of a pixel -> same word assembled, single strobe, no strobe during gap.
- Full frame + restart: 256 pixels -> 256 strobes total, 32 per half per bank; oem_finish high 1 cycle after last strobe. Extra bits cause no strobe; restart -> oem_finish=0, next pixel lands at odd_wr[0] addr0.
- Reset mid-frame: rst after 4 bits of pixel 10 -> no strobe, next full pixel routed as p0; with DAC_OVERRUN_EN, bits in DONE set overrun=1 and restart clears it.
